// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_pkg
//  Description : Shared types, constants and the forwarding-select helper
//                for the 5-stage pipeline hazard unit.
//                - fwd_sel_e  : EXE operand source select encoding
//                - reg_addr_t : widest register address the helper accepts
//                - REG_ZERO   : hardwired zero register address
//                - fwd_select : MEM-over-WB forwarding priority for one operand
//  Revision    : 1.0  initial release
// ============================================================================
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    // Callers zero-extend their REG_ADDR_W-bit addresses to this width, so
    // one helper serves any register-file size up to 2^32 entries.
    localparam int unsigned REG_ADDR_MAX_W = 32;
    typedef logic [REG_ADDR_MAX_W-1:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = '0;

    // The zero register never forwards: a write to r0 is discarded by the
    // register file, so the architectural value is always the regfile read.
    // Once src is known to be non-zero, a match on rd implies rd is non-zero.
    function automatic fwd_sel_e fwd_select(
        input reg_addr_t src,
        input logic      wr_mem,
        input reg_addr_t rd_mem,
        input logic      wr_wb,
        input reg_addr_t rd_wb
    );
        fwd_sel_e sel;
        sel = FWD_REG;
        if (src != REG_ZERO) begin
            // MEM holds the younger producer, so it wins over WB.
            if (wr_mem && (rd_mem == src)) begin
                sel = FWD_MEM;
            end else if (wr_wb && (rd_wb == src)) begin
                sel = FWD_WB;
            end
        end
        return sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_busy_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_busy_tracker
//  Description : Tracks an in-flight multi-cycle MDU operation. A start pulse
//                loads a down-counter with MDU_LATENCY; the unit is busy while
//                the counter is non-zero. A start arriving while busy reloads
//                the counter and sets a sticky overlap error.
//  Ports       : clk         - clock, rising edge
//                reset       - synchronous, active-high
//                start       - MDU op issuing this cycle
//                busy        - an MDU op is in flight
//                overlap_err - sticky: start seen while busy
//  Revision    : 1.0  initial release
// ============================================================================
module mdu_busy_tracker #(
    parameter int MDU_LATENCY = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic busy,
    output logic overlap_err
);

    generate
        if (MDU_LATENCY == 0) begin : g_never_busy
            // A zero-latency MDU is never busy, so no overlap can occur.
            assign busy        = 1'b0;
            assign overlap_err = 1'b0;
        end else begin : g_counter
            localparam int              c_cnt_w = $clog2(MDU_LATENCY + 1);
            localparam logic [c_cnt_w-1:0] c_load = c_cnt_w'(MDU_LATENCY);

            logic [c_cnt_w-1:0] r_cnt;
            logic               r_err;

            // Free-running: pipeline stalls and flushes do not cancel an op
            // that has already left EXE, so nothing but reset touches this.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_cnt <= '0;
                    r_err <= 1'b0;
                end else if (start) begin
                    r_cnt <= c_load;
                    if (r_cnt != '0) begin
                        r_err <= 1'b1;
                    end
                end else if (r_cnt != '0) begin
                    r_cnt <= r_cnt - c_cnt_w'(1);
                end
            end

            assign busy        = (r_cnt != '0);
            assign overlap_err = r_err;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/hazard_unit.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_unit
//  Description : Pipeline control-flow block for the 5-stage MIPS core.
//                Detects load-use and MDU-busy hazards, generates stall and
//                flush controls, EXE-stage forwarding selects, tracks MDU
//                occupancy and counts stall cycles (saturating).
//  Ports       : clk, reset                 - clock / sync active-high reset
//                rs_DEC, rt_DEC, *_used_DEC - DEC source registers and usage
//                mdu_use_DEC                - DEC instr needs the MDU / HI/LO
//                rs_EXE, rt_EXE, rd_EXE     - EXE register addresses
//                memread_EXE                - EXE instr is a load
//                mdu_start_EXE              - MDU op issues from EXE
//                branch_taken_EXE           - control transfer taken in EXE
//                rd_MEM/WB, regwrite_MEM/WB - later-stage writebacks
//                stall_IF, stall_DEC        - hold PC and IF/DEC register
//                flush_DEC, flush_EXE       - bubble into DEC / EXE
//                fwd_a_EXE, fwd_b_EXE       - operand selects (00/01/10)
//                mdu_busy                   - MDU op in flight
//                stall_count                - saturating stall-cycle count
//                mdu_overlap_err            - sticky MDU overlap flag
//  Revision    : 1.0  initial release
// ============================================================================
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W  = 5,
    parameter int MDU_LATENCY = 8,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [REG_ADDR_W-1:0]  rs_DEC,
    input  logic [REG_ADDR_W-1:0]  rt_DEC,
    input  logic                   rs_used_DEC,
    input  logic                   rt_used_DEC,
    input  logic                   mdu_use_DEC,
    input  logic [REG_ADDR_W-1:0]  rs_EXE,
    input  logic [REG_ADDR_W-1:0]  rt_EXE,
    input  logic [REG_ADDR_W-1:0]  rd_EXE,
    input  logic                   memread_EXE,
    input  logic                   mdu_start_EXE,
    input  logic                   branch_taken_EXE,
    input  logic [REG_ADDR_W-1:0]  rd_MEM,
    input  logic [REG_ADDR_W-1:0]  rd_WB,
    input  logic                   regwrite_MEM,
    input  logic                   regwrite_WB,
    output logic                   stall_IF,
    output logic                   stall_DEC,
    output logic                   flush_DEC,
    output logic                   flush_EXE,
    output logic [1:0]             fwd_a_EXE,
    output logic [1:0]             fwd_b_EXE,
    output logic                   mdu_busy,
    output logic [STALL_CNT_W-1:0] stall_count,
    output logic                   mdu_overlap_err
);

    localparam logic [STALL_CNT_W-1:0] c_cnt_max = '1;

    logic                   w_mdu_busy;
    logic                   w_overlap_err;
    logic                   w_lu;
    logic                   w_mh;
    logic                   w_hazard;
    logic                   w_stall;
    logic [1:0]             w_fwd_a;
    logic [1:0]             w_fwd_b;
    logic [STALL_CNT_W-1:0] r_stall_cnt;

    mdu_busy_tracker #(
        .MDU_LATENCY (MDU_LATENCY)
    ) u_mdu_busy_tracker (
        .clk         (clk),
        .reset       (reset),
        .start       (mdu_start_EXE),
        .busy        (w_mdu_busy),
        .overlap_err (w_overlap_err)
    );

    // A load into r0 produces nothing usable, so it never blocks DEC.
    assign w_lu = memread_EXE && (rd_EXE != '0) &&
                  ((rs_used_DEC && (rs_DEC == rd_EXE)) ||
                   (rt_used_DEC && (rt_DEC == rd_EXE)));

    assign w_mh     = mdu_use_DEC && w_mdu_busy;
    assign w_hazard = w_lu || w_mh;

    // A taken branch kills the DEC instruction, so holding it is pointless.
    assign w_stall = w_hazard && !branch_taken_EXE && !reset;

    assign stall_IF  = w_stall;
    assign stall_DEC = w_stall;
    assign flush_DEC = reset || branch_taken_EXE;
    // On a stall the instruction in DEC is held, so EXE must receive a bubble.
    assign flush_EXE = reset || branch_taken_EXE || w_hazard;

    assign w_fwd_a = fwd_select(reg_addr_t'(rs_EXE), regwrite_MEM,
                                reg_addr_t'(rd_MEM), regwrite_WB,
                                reg_addr_t'(rd_WB));
    assign w_fwd_b = fwd_select(reg_addr_t'(rt_EXE), regwrite_MEM,
                                reg_addr_t'(rd_MEM), regwrite_WB,
                                reg_addr_t'(rd_WB));

    assign fwd_a_EXE = reset ? 2'b00 : w_fwd_a;
    assign fwd_b_EXE = reset ? 2'b00 : w_fwd_b;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != c_cnt_max)) begin
            r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
        end
    end

    assign mdu_busy        = w_mdu_busy;
    assign mdu_overlap_err = w_overlap_err;
    assign stall_count     = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hazard_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_unit
//  Description : Self-checking bench for hazard_unit. Directed scenarios plus
//                randomized traffic compared against a behavioural model that
//                tracks remaining MDU busy cycles and a saturating stall count.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_hazard_unit;

    localparam int AW  = 5;
    localparam int LAT = 4;
    localparam int CW  = 8;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] rs_DEC, rt_DEC, rs_EXE, rt_EXE, rd_EXE, rd_MEM, rd_WB;
    logic          rs_used_DEC, rt_used_DEC, mdu_use_DEC, memread_EXE;
    logic          mdu_start_EXE, branch_taken_EXE, regwrite_MEM, regwrite_WB;
    logic          stall_IF, stall_DEC, flush_DEC, flush_EXE;
    logic [1:0]    fwd_a_EXE, fwd_b_EXE;
    logic          mdu_busy, mdu_overlap_err;
    logic [CW-1:0] stall_count;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state
    int m_busy_left = 0;
    bit m_err       = 1'b0;
    int m_cnt       = 0;

    always #5 clk = ~clk;

    hazard_unit #(
        .REG_ADDR_W  (AW),
        .MDU_LATENCY (LAT),
        .STALL_CNT_W (CW)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .rs_DEC           (rs_DEC),
        .rt_DEC           (rt_DEC),
        .rs_used_DEC      (rs_used_DEC),
        .rt_used_DEC      (rt_used_DEC),
        .mdu_use_DEC      (mdu_use_DEC),
        .rs_EXE           (rs_EXE),
        .rt_EXE           (rt_EXE),
        .rd_EXE           (rd_EXE),
        .memread_EXE      (memread_EXE),
        .mdu_start_EXE    (mdu_start_EXE),
        .branch_taken_EXE (branch_taken_EXE),
        .rd_MEM           (rd_MEM),
        .rd_WB            (rd_WB),
        .regwrite_MEM     (regwrite_MEM),
        .regwrite_WB      (regwrite_WB),
        .stall_IF         (stall_IF),
        .stall_DEC        (stall_DEC),
        .flush_DEC        (flush_DEC),
        .flush_EXE        (flush_EXE),
        .fwd_a_EXE        (fwd_a_EXE),
        .fwd_b_EXE        (fwd_b_EXE),
        .mdu_busy         (mdu_busy),
        .stall_count      (stall_count),
        .mdu_overlap_err  (mdu_overlap_err)
    );

    // ---------------- reference model ----------------
    function automatic bit f_lu();
        if (!memread_EXE || rd_EXE == 0) return 1'b0;
        return (rs_used_DEC && rs_DEC == rd_EXE) || (rt_used_DEC && rt_DEC == rd_EXE);
    endfunction

    function automatic bit f_hazard();
        return f_lu() || (mdu_use_DEC && m_busy_left > 0);
    endfunction

    function automatic bit f_stall();
        return f_hazard() && !branch_taken_EXE && !reset;
    endfunction

    function automatic logic [1:0] f_fwd(input logic [AW-1:0] src);
        if (reset || src == 0)            return 2'b00;
        if (regwrite_MEM && rd_MEM == src) return 2'b10;
        if (regwrite_WB && rd_WB == src)   return 2'b01;
        return 2'b00;
    endfunction

    // {stall_IF, stall_DEC, flush_DEC, flush_EXE, fwd_a, fwd_b, busy, err}
    function automatic logic [9:0] f_expect();
        bit s;
        s = f_stall();
        return {s, s, reset || branch_taken_EXE,
                reset || branch_taken_EXE || f_hazard(),
                f_fwd(rs_EXE), f_fwd(rt_EXE), m_busy_left > 0, m_err};
    endfunction

    // Advance one clock edge and update the model with the inputs seen there.
    task automatic tick();
        bit st;
        st = f_stall();
        @(posedge clk);
        if (reset) begin
            m_busy_left = 0;
            m_err       = 1'b0;
            m_cnt       = 0;
        end else begin
            if (st && m_cnt < CNT_MAX) m_cnt++;
            if (mdu_start_EXE) begin
                if (m_busy_left > 0) m_err = 1'b1;
                m_busy_left = LAT;
            end else if (m_busy_left > 0) begin
                m_busy_left--;
            end
        end
        #1;
    endtask

    task automatic idle();
        reset = 0; rs_DEC = 0; rt_DEC = 0; rs_used_DEC = 0; rt_used_DEC = 0;
        mdu_use_DEC = 0; rs_EXE = 0; rt_EXE = 0; rd_EXE = 0; memread_EXE = 0;
        mdu_start_EXE = 0; branch_taken_EXE = 0; rd_MEM = 0; rd_WB = 0;
        regwrite_MEM = 0; regwrite_WB = 0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        idle();
        reset = 1;
        rs_EXE = 3; rd_MEM = 3; regwrite_MEM = 1;
        #1;
        n_chk++;
        if ({stall_IF, stall_DEC, flush_DEC, flush_EXE, fwd_a_EXE, fwd_b_EXE} !== 8'b0011_0000) begin
            n_fail++;
            $display("FAIL reset_comb: got %b want 00110000",
                     {stall_IF, stall_DEC, flush_DEC, flush_EXE, fwd_a_EXE, fwd_b_EXE});
        end
        tick();
        idle();
        #1;
        n_chk++;
        if ({mdu_busy, mdu_overlap_err, stall_count} !== {2'b00, {CW{1'b0}}}) begin
            n_fail++;
            $display("FAIL reset_state: busy=%b err=%b cnt=%0d want 0 0 0",
                     mdu_busy, mdu_overlap_err, stall_count);
        end
    endtask

    task automatic test_load_use();
        idle();
        memread_EXE = 1; rd_EXE = 5; rs_DEC = 5; rs_used_DEC = 1;
        #1;
        n_chk++;
        if ({stall_IF, stall_DEC, flush_DEC, flush_EXE} !== 4'b1101) begin
            n_fail++;
            $display("FAIL load_use_stall: got %b want 1101",
                     {stall_IF, stall_DEC, flush_DEC, flush_EXE});
        end
        tick();
        memread_EXE = 0;
        #1;
        n_chk++;
        if ({stall_IF, stall_DEC, flush_DEC, flush_EXE} !== 4'b0000) begin
            n_fail++;
            $display("FAIL load_use_release: got %b want 0000",
                     {stall_IF, stall_DEC, flush_DEC, flush_EXE});
        end
        n_chk++;
        if (stall_count !== CW'(1)) begin
            n_fail++;
            $display("FAIL load_use_count: got %0d want 1", stall_count);
        end
        tick();
    endtask

    task automatic test_zero_and_unused();
        idle();
        memread_EXE = 1; rd_EXE = 0; rs_DEC = 0; rs_used_DEC = 1;
        #1;
        n_chk++;
        if ({stall_IF, stall_DEC, flush_EXE} !== 3'b000) begin
            n_fail++;
            $display("FAIL zero_reg: got %b want 000", {stall_IF, stall_DEC, flush_EXE});
        end
        tick();
        rd_EXE = 7; rt_DEC = 7; rt_used_DEC = 0; rs_DEC = 1;
        #1;
        n_chk++;
        if ({stall_IF, stall_DEC, flush_EXE} !== 3'b000) begin
            n_fail++;
            $display("FAIL unused_src: got %b want 000", {stall_IF, stall_DEC, flush_EXE});
        end
        tick();
        rt_used_DEC = 1;
        #1;
        n_chk++;
        if ({stall_IF, stall_DEC, flush_EXE} !== 3'b111) begin
            n_fail++;
            $display("FAIL rt_used_src: got %b want 111", {stall_IF, stall_DEC, flush_EXE});
        end
        tick();
    endtask

    task automatic test_forward();
        idle();
        rs_EXE = 3; rd_MEM = 3; rd_WB = 3; regwrite_MEM = 1; regwrite_WB = 1;
        #1;
        n_chk++;
        if (fwd_a_EXE !== 2'b10) begin
            n_fail++;
            $display("FAIL fwd_mem_priority: got %b want 10", fwd_a_EXE);
        end
        tick();
        regwrite_MEM = 0;
        #1;
        n_chk++;
        if (fwd_a_EXE !== 2'b01) begin
            n_fail++;
            $display("FAIL fwd_wb: got %b want 01", fwd_a_EXE);
        end
        tick();
        rs_EXE = 0; rt_EXE = 3; rd_WB = 0; regwrite_WB = 1; regwrite_MEM = 1;
        #1;
        n_chk++;
        if ({fwd_a_EXE, fwd_b_EXE} !== 4'b0010) begin
            n_fail++;
            $display("FAIL fwd_zero_src: got a=%b b=%b want a=00 b=10", fwd_a_EXE, fwd_b_EXE);
        end
        tick();
    endtask

    task automatic test_mdu();
        idle();
        // Single op: busy in cycles 1..LAT, DEC user stalls from 2 until LAT+1.
        for (int c = 0; c <= 6; c++) begin
            mdu_start_EXE = (c == 0);
            mdu_use_DEC   = (c >= 2);
            #1;
            n_chk++;
            if ({mdu_busy, stall_DEC} !== {(c >= 1 && c <= LAT), (c >= 2 && c <= LAT)}) begin
                n_fail++;
                $display("FAIL mdu_single c=%0d: busy=%b stall=%b want %b %b", c,
                         mdu_busy, stall_DEC, (c >= 1 && c <= LAT), (c >= 2 && c <= LAT));
            end
            tick();
        end
        // Overlapping start at cycle 3 reloads and raises the sticky error.
        for (int c = 0; c <= 10; c++) begin
            mdu_start_EXE = (c == 0 || c == 3);
            mdu_use_DEC   = (c >= 2);
            #1;
            n_chk++;
            if ({mdu_busy, stall_DEC, mdu_overlap_err} !==
                {m_busy_left > 0, f_stall(), m_err}) begin
                n_fail++;
                $display("FAIL mdu_overlap c=%0d: busy/stall/err=%b%b%b want %b%b%b", c,
                         mdu_busy, stall_DEC, mdu_overlap_err,
                         m_busy_left > 0, f_stall(), m_err);
            end
            tick();
        end
        n_chk++;
        if (mdu_overlap_err !== 1'b1) begin
            n_fail++;
            $display("FAIL mdu_err_sticky: got %b want 1", mdu_overlap_err);
        end
    endtask

    task automatic test_branch_priority();
        int cnt_before;
        idle();
        memread_EXE = 1; rd_EXE = 9; rs_DEC = 9; rs_used_DEC = 1; branch_taken_EXE = 1;
        #1;
        n_chk++;
        if ({stall_IF, stall_DEC, flush_DEC, flush_EXE} !== 4'b0011) begin
            n_fail++;
            $display("FAIL branch_prio: got %b want 0011",
                     {stall_IF, stall_DEC, flush_DEC, flush_EXE});
        end
        cnt_before = m_cnt;
        tick();
        n_chk++;
        if (stall_count !== CW'(cnt_before)) begin
            n_fail++;
            $display("FAIL branch_count: got %0d want %0d", stall_count, cnt_before);
        end
    endtask

    task automatic test_reset_mid_op();
        idle();
        mdu_start_EXE = 1;
        tick();               // cycle 0: op issues
        tick();               // cycle 1: overlapping issue sets the error
        mdu_start_EXE = 0;
        reset = 1; mdu_use_DEC = 1; memread_EXE = 1; rd_EXE = 4; rt_DEC = 4; rt_used_DEC = 1;
        #1;
        n_chk++;
        if ({stall_IF, flush_DEC, flush_EXE, mdu_busy, mdu_overlap_err} !== 5'b01111) begin
            n_fail++;
            $display("FAIL reset_mid_op_comb: got %b want 01111",
                     {stall_IF, flush_DEC, flush_EXE, mdu_busy, mdu_overlap_err});
        end
        tick();
        idle();
        #1;
        n_chk++;
        if ({mdu_busy, mdu_overlap_err, stall_count} !== {2'b00, {CW{1'b0}}}) begin
            n_fail++;
            $display("FAIL reset_mid_op_state: busy=%b err=%b cnt=%0d want 0 0 0",
                     mdu_busy, mdu_overlap_err, stall_count);
        end
    endtask

    task automatic test_random();
        logic [9:0] exp_v;
        for (int i = 0; i < 1500; i++) begin
            reset            = ($urandom_range(0, 63) == 0);
            rs_DEC           = AW'($urandom_range(0, 3));
            rt_DEC           = AW'($urandom_range(0, 3));
            rs_EXE           = AW'($urandom_range(0, 3));
            rt_EXE           = AW'($urandom_range(0, 3));
            rd_EXE           = AW'($urandom_range(0, 3));
            rd_MEM           = AW'($urandom_range(0, 3));
            rd_WB            = AW'($urandom_range(0, 3));
            rs_used_DEC      = 1'($urandom);
            rt_used_DEC      = 1'($urandom);
            mdu_use_DEC      = 1'($urandom);
            memread_EXE      = 1'($urandom);
            regwrite_MEM     = 1'($urandom);
            regwrite_WB      = 1'($urandom);
            mdu_start_EXE    = ($urandom_range(0, 5) == 0);
            branch_taken_EXE = ($urandom_range(0, 7) == 0);
            #1;
            exp_v = f_expect();
            n_chk++;
            if ({stall_IF, stall_DEC, flush_DEC, flush_EXE, fwd_a_EXE, fwd_b_EXE,
                 mdu_busy, mdu_overlap_err} !== exp_v) begin
                n_fail++;
                $display("FAIL random_outputs i=%0d: got %b want %b", i,
                         {stall_IF, stall_DEC, flush_DEC, flush_EXE, fwd_a_EXE, fwd_b_EXE,
                          mdu_busy, mdu_overlap_err}, exp_v);
            end
            n_chk++;
            if (stall_count !== CW'(m_cnt)) begin
                n_fail++;
                $display("FAIL random_count i=%0d: got %0d want %0d", i, stall_count, m_cnt);
            end
            tick();
        end
    endtask

    task automatic test_saturation();
        idle();
        reset = 1;
        tick();
        reset = 0;
        memread_EXE = 1; rd_EXE = 5; rs_DEC = 5; rs_used_DEC = 1;
        repeat ((1 << CW) + 3) tick();
        n_chk++;
        if (stall_count !== CW'(CNT_MAX) || m_cnt != CNT_MAX) begin
            n_fail++;
            $display("FAIL stall_saturate: got %0d want %0d", stall_count, CNT_MAX);
        end
        n_chk++;
        if (stall_DEC !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_hold_at_sat: got %b want 1", stall_DEC);
        end
        idle();
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        @(posedge clk);
        #1;
        test_reset();
        test_load_use();
        test_zero_and_unused();
        test_forward();
        test_mdu();
        test_branch_priority();
        test_reset_mid_op();
        test_random();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
Parametrised successor to the pipeline control-flow block for the 5-stage MIPS core (IF/DEC/EXE/MEM/WB). It detects load-use hazards and multi-cycle MDU (mul/div) hazards, and issues stalls and flushes. It also produces EXE-stage forwarding selects and handles taken-branch flushes. It keeps an internal MDU busy tracker and a saturating stall-cycle counter for performance monitoring.

Parameters:
REG_ADDR_W, 5, register address width; address 0 is the hardwired zero register.
MDU_LATENCY, 8, cycles an MDU op stays busy after mdu_start_EXE; 0 means the MDU is never busy.
STALL_CNT_W, 16, width of the saturating stall counter.

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high
rs_DEC, rt_DEC  in  REG_ADDR_W  source registers of the instruction in DEC
rs_used_DEC, rt_used_DEC  in  1  the corresponding source is actually read
mdu_use_DEC  in  1  the DEC instruction is an MDU op or reads HI/LO
rs_EXE, rt_EXE  in  REG_ADDR_W  source registers of the instruction in EXE
rd_EXE  in  REG_ADDR_W  destination register in EXE
memread_EXE  in  1  the EXE instruction is a load
mdu_start_EXE  in  1  an MDU op is issuing from EXE this cycle
branch_taken_EXE  in  1  the branch or jump resolved taken in EXE
rd_MEM, rd_WB  in  REG_ADDR_W  destination registers in MEM and WB
regwrite_MEM, regwrite_WB  in  1  the corresponding register write is enabled
stall_IF, stall_DEC  out  1  hold the PC and the IF/DEC register
flush_DEC, flush_EXE  out  1  insert a bubble into the DEC and EXE stage registers
fwd_a_EXE, fwd_b_EXE  out  2  operand select for rs/rt: 00 = regfile, 01 = WB, 10 = MEM
mdu_busy  out  1  the MDU has an op in flight
stall_count  out  STALL_CNT_W  number of cycles with stall_DEC=1, saturating
mdu_overlap_err  out  1  sticky flag: mdu_start_EXE arrived while mdu_busy=1

Behaviour:
- Clock and reset:
  - One clock, clk. reset is synchronous and active-high.
  - While reset=1: stall_IF=stall_DEC=0, flush_DEC=flush_EXE=1, fwd selects 00.
  - Registered state after the reset edge: mdu_busy=0, MDU counter=0, stall_count=0, mdu_overlap_err=0.
  - A reset during an MDU op abandons it; busy clears on the next edge.
- Stall, flush and forwarding outputs are combinational from the inputs and the registered state, with zero latency.
- Load-use hazard (lu):
  - Asserted when memread_EXE & rd_EXE != 0 & ((rs_used_DEC & rs_DEC == rd_EXE) | (rt_used_DEC & rt_DEC == rd_EXE)).
- MDU hazard (mh):
  - Asserted when mdu_use_DEC & mdu_busy.
- Stall:
  - stall_IF = stall_DEC = (lu | mh) & ~branch_taken_EXE & ~reset.
- Flush:
  - flush_EXE = reset | branch_taken_EXE | ((lu | mh) & ~branch_taken_EXE). A bubble is inserted behind the stalled instruction.
  - flush_DEC = reset | branch_taken_EXE.
  - A taken branch has priority over both stalls: the DEC instruction is killed, so no stall is needed.
- Forwarding, evaluated per operand (a uses rs_EXE, b uses rt_EXE):
  - Select 10 if regwrite_MEM & rd_MEM != 0 & rd_MEM matches.
  - Else select 01 if regwrite_WB & rd_WB != 0 & rd_WB matches.
  - Else select 00.
  - MEM wins when MEM and WB both match. Source register 0 always gives 00.
- MDU tracker:
  - cnt is a $clog2(MDU_LATENCY+1)-bit register.
  - On mdu_start_EXE: cnt <= MDU_LATENCY. Otherwise, if cnt != 0: cnt <= cnt-1.
  - mdu_busy = (cnt != 0).
  - mdu_start_EXE while busy: cnt reloads, mdu_overlap_err is set and holds until reset.
  - The counter decrements regardless of stalls and flushes. An op already in EXE is not cancelled by a branch flush.
- stall_count:
  - Increments on every edge where stall_DEC=1 and reset=0.
  - Saturates at all-ones; no wrap.
- Simultaneous lu and mh: a single stall with the same outputs; the counter increments once.

Decomposition:
- hazard_pkg holds:
  - enum fwd_sel_e: FWD_REG = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10.
  - localparam REG_ZERO = '0.
- Natural sub-module: mdu_busy_tracker (parameter MDU_LATENCY; ports clk, reset, start; outputs busy, overlap_err).
- Forwarding compare is a function in hazard_pkg, instantiated twice, once per operand.

Test Plan:
- Load-use: memread_EXE=1, rd_EXE=5, rs_DEC=5, rs_used_DEC=1 -> stall_IF=stall_DEC=1, flush_EXE=1, flush_DEC=0; the next cycle with memread_EXE=0 gives all zero; stall_count=1.
- Zero register and unused source: rd_EXE=0, rs_DEC=0 gives no stall; rt_DEC=rd_EXE=7 with rt_used_DEC=0 also gives no stall.
- Forward priority: rs_EXE=3, rd_MEM=rd_WB=3, both regwrites set -> fwd_a_EXE=10; clear regwrite_MEM -> 01; rs_EXE=0 -> 00.
- MDU: MDU_LATENCY=4, start pulse at cycle 0 -> mdu_busy=1 for cycles 1-4; mdu_use_DEC=1 at cycle 2 -> stall, released at cycle 5; start at cycle 3 -> mdu_overlap_err=1 and it stays set.
- Branch priority: lu conditions together with branch_taken_EXE=1 -> stall_IF=0, flush_DEC=flush_EXE=1, stall_count unchanged.
- Reset mid-op: reset at cycle 2 of an MDU op -> mdu_busy=0, stall_count=0 and mdu_overlap_err=0 after the edge; flush_DEC=flush_EXE=1 while reset=1. Separately, force 2^STALL_CNT_W+3 stall cycles -> stall_count holds at all-ones.
